// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates data/instruction cache requests onto one RAM
// port and returns per-port wait/load handshakes, with debug counters and sticky error.
module mem_responder #(
  parameter int WORD_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err,
  output logic [CNT_W-1:0]  dcount,
  output logic [CNT_W-1:0]  icount
);

  localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   dcount_q, dcount_d;
  logic [CNT_W-1:0]   icount_q, icount_d;

  // Owner-independent view of the granted request.
  logic               gnt_active;
  logic               gnt_req;
  logic               gnt_wr;
  logic [WORD_W-1:0]  gnt_addr;
  logic [WORD_W-1:0]  gnt_store;
  logic               done_ok;
  logic               done_err;
  logic               done;

  always_comb begin
    gnt_active = 1'b0;
    gnt_req    = 1'b0;
    gnt_wr     = 1'b0;
    gnt_addr   = '0;
    gnt_store  = '0;
    case (state_q)
      DGNT: begin
        gnt_active = 1'b1;
        gnt_req    = dREN | dWEN;
        gnt_wr     = dWEN;
        gnt_addr   = daddr;
        gnt_store  = dstore;
      end
      IGNT: begin
        gnt_active = 1'b1;
        gnt_req    = iREN;
        gnt_addr   = iaddr;
      end
      default: ;
    endcase
  end

  // A RAM answer in the same cycle as the limit is honoured as a normal completion.
  always_comb begin
    done_ok  = gnt_active && gnt_req && (ramstate == RAM_ACCESS);
    done_err = gnt_active && gnt_req && !done_ok &&
               ((ramstate == RAM_ERROR) || (tmo_q == TMO_LIM));
    done     = done_ok || done_err;
  end

  always_comb begin
    ramREN   = gnt_active && gnt_req && !gnt_wr;
    ramWEN   = gnt_active && gnt_req && gnt_wr;
    ramaddr  = gnt_active ? gnt_addr : '0;
    ramstore = gnt_active ? gnt_store : '0;

    dwait = 1'b1;
    dload = '0;
    iwait = 1'b1;
    iload = '0;
    if (state_q == DGNT && done) begin
      dwait = 1'b0;
      dload = done_ok ? ramload : '0;
    end
    if (state_q == IGNT && done) begin
      iwait = 1'b0;
      iload = done_ok ? ramload : '0;
    end

    err    = err_q;
    dcount = dcount_q;
    icount = icount_q;
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = '0;
    err_d    = err_q | done_err;
    dcount_d = dcount_q;
    icount_d = icount_q;
    case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end
      DGNT, IGNT: begin
        if (!gnt_req || done) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        if (done_ok && state_q == DGNT) dcount_d = dcount_q + CNT_W'(1);
        if (done_ok && state_q == IGNT) icount_d = icount_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      dcount_q <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      dcount_q <= dcount_d;
      icount_q <= icount_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios followed by random
// transactions checked against a transaction-level model of latency and completion.
module tb_mem_responder;

  localparam int W   = 32;
  localparam int CNT = 2;
  localparam int TMO = 4;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           dREN = 1'b0, dWEN = 1'b0, iREN = 1'b0;
  logic [W-1:0]   daddr = '0, dstore = '0, iaddr = '0, ramload = '0;
  logic [1:0]     ramstate = FREE;
  logic           dwait, iwait, ramREN, ramWEN, err;
  logic [W-1:0]   dload, iload, ramaddr, ramstore;
  logic [CNT-1:0] dcount, icount;

  int total = 0;
  int bad   = 0;
  int dcnt_e = 0;
  int icnt_e = 0;
  bit err_e  = 1'b0;

  mem_responder #(.WORD_W(W), .CNT_W(CNT), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .err(err), .dcount(dcount), .icount(icount)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_hs(input string tag, input logic dw, input logic iw,
                        input logic [31:0] dl, input logic [31:0] il,
                        input logic rr, input logic rw);
    chk({tag, ".dwait"}, 32'(dwait), 32'(dw));
    chk({tag, ".iwait"}, 32'(iwait), 32'(iw));
    chk({tag, ".dload"}, dload, dl);
    chk({tag, ".iload"}, iload, il);
    chk({tag, ".ramREN"}, 32'(ramREN), 32'(rr));
    chk({tag, ".ramWEN"}, 32'(ramWEN), 32'(rw));
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".dcount"}, 32'(dcount), 32'(dcnt_e));
    chk({tag, ".icount"}, 32'(icount), 32'(icnt_e));
    chk({tag, ".err"}, 32'(err), 32'(err_e));
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // One whole transaction from an idle responder. nbusy = stall cycles before RAM answers.
  task automatic run_txn(input string tag, input bit is_d, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int nbusy, input bit end_err, input logic [31:0] rdata);
    bit tmo_hit;
    bit ok;
    int gc;
    tmo_hit = (nbusy > TMO);
    gc      = tmo_hit ? TMO + 1 : nbusy + 1;
    ok      = !tmo_hit && !end_err;

    dWEN   = is_d && wr;
    dREN   = is_d && (!wr || ($urandom_range(0, 1) == 1));
    iREN   = !is_d;
    daddr  = is_d ? addr : 32'($urandom);
    iaddr  = is_d ? 32'($urandom) : addr;
    dstore = wdata;
    ramstate = FREE;
    @(negedge CLK);
    chk_hs({tag, ".req"}, 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);

    for (int g = 1; g <= gc; g++) begin
      next_cycle();
      if (g < gc) ramstate = ($urandom_range(0, 1) == 1) ? BUSY : FREE;
      else        ramstate = tmo_hit ? BUSY : (end_err ? ERROR : ACCESS);
      ramload = (g == gc) ? rdata : 32'($urandom);
      @(negedge CLK);
      if (g == gc) begin
        if (is_d) chk_hs({tag, ".done"}, 1'b0, 1'b1, ok ? rdata : '0, '0, !wr, wr);
        else      chk_hs({tag, ".done"}, 1'b1, 1'b0, '0, ok ? rdata : '0, 1'b1, 1'b0);
      end else begin
        chk_hs({tag, ".wait"}, 1'b1, 1'b1, '0, '0, !(is_d && wr), is_d && wr);
      end
      chk({tag, ".ramaddr"}, ramaddr, addr);
      if (is_d) chk({tag, ".ramstore"}, ramstore, wdata);
    end

    next_cycle();
    dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0; ramstate = FREE;
    if (ok) begin
      if (is_d) dcnt_e = (dcnt_e + 1) % (1 << CNT);
      else      icnt_e = (icnt_e + 1) % (1 << CNT);
    end else begin
      err_e = 1'b1;
    end
    @(negedge CLK);
    chk_hs({tag, ".after"}, 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
    chk_state(tag);
    next_cycle();
  endtask

  initial begin
    RST = 1'b1;
    #12;
    chk_hs("reset", 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
    chk("reset.ramaddr", ramaddr, '0);
    chk("reset.ramstore", ramstore, '0);
    chk_state("reset");
    @(negedge CLK);
    RST = 1'b0;
    next_cycle();

    run_txn("rd_fast", 1'b1, 1'b0, 32'h0000_1000, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
    run_txn("wr_busy", 1'b1, 1'b1, 32'h0000_3100, 32'h0000_002A, 3, 1'b0, 32'h1111_2222);

    // Simultaneous requests: data first, instruction after one idle cycle.
    dREN = 1'b1; iREN = 1'b1; daddr = 32'hA000; iaddr = 32'hB000;
    @(negedge CLK);
    chk_hs("both.c0", 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
    next_cycle();
    ramstate = ACCESS; ramload = 32'h1234_5678;
    @(negedge CLK);
    chk_hs("both.d", 1'b0, 1'b1, 32'h1234_5678, '0, 1'b1, 1'b0);
    chk("both.daddr", ramaddr, 32'hA000);
    dcnt_e = (dcnt_e + 1) % (1 << CNT);
    next_cycle();
    dREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk_hs("both.idle", 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
    next_cycle();
    ramstate = ACCESS; ramload = 32'h8765_4321;
    @(negedge CLK);
    chk_hs("both.i", 1'b1, 1'b0, '0, 32'h8765_4321, 1'b1, 1'b0);
    chk("both.iaddr", ramaddr, 32'hB000);
    icnt_e = (icnt_e + 1) % (1 << CNT);
    next_cycle();
    iREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk_state("both");
    next_cycle();

    // Instruction grant held while a data write arrives.
    iREN = 1'b1; iaddr = 32'hC000;
    next_cycle();
    ramstate = BUSY;
    @(negedge CLK);
    chk_hs("ihold.b1", 1'b1, 1'b1, '0, '0, 1'b1, 1'b0);
    next_cycle();
    dWEN = 1'b1; daddr = 32'hD000; dstore = 32'h55;
    @(negedge CLK);
    chk_hs("ihold.b2", 1'b1, 1'b1, '0, '0, 1'b1, 1'b0);
    chk("ihold.addr", ramaddr, 32'hC000);
    next_cycle();
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    @(negedge CLK);
    chk_hs("ihold.done", 1'b1, 1'b0, '0, 32'h0BAD_F00D, 1'b1, 1'b0);
    icnt_e = (icnt_e + 1) % (1 << CNT);
    next_cycle();
    iREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk_hs("ihold.idle", 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
    next_cycle();
    ramstate = ACCESS; ramload = 32'h7;
    @(negedge CLK);
    chk_hs("ihold.d", 1'b0, 1'b1, 32'h7, '0, 1'b0, 1'b1);
    chk("ihold.dstore", ramstore, 32'h55);
    dcnt_e = (dcnt_e + 1) % (1 << CNT);
    next_cycle();
    dWEN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk_state("ihold");
    next_cycle();

    run_txn("timeout", 1'b1, 1'b0, 32'h0000_4000, 32'h0, 10, 1'b0, 32'hFFFF_FFFF);
    run_txn("err_sticky", 1'b0, 1'b0, 32'h0000_4004, 32'h0, 1, 1'b0, 32'h0000_00AB);

    // Request withdrawn mid-grant: silent return to idle.
    dREN = 1'b1; daddr = 32'h5000;
    next_cycle();
    ramstate = BUSY;
    @(negedge CLK);
    chk_hs("drop.b", 1'b1, 1'b1, '0, '0, 1'b1, 1'b0);
    next_cycle();
    dREN = 1'b0; ramstate = ACCESS; ramload = 32'h9999;
    @(negedge CLK);
    chk("drop.dwait", 32'(dwait), 32'd1);
    chk("drop.dload", dload, '0);
    next_cycle();
    ramstate = FREE;
    @(negedge CLK);
    chk_hs("drop.idle", 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
    chk_state("drop");
    next_cycle();

    // Asynchronous reset during a stalled data grant.
    dREN = 1'b1; daddr = 32'h6000;
    next_cycle();
    ramstate = BUSY;
    @(negedge CLK);
    chk_hs("rstmid.b", 1'b1, 1'b1, '0, '0, 1'b1, 1'b0);
    #1 RST = 1'b1;
    #1;
    dcnt_e = 0; icnt_e = 0; err_e = 1'b0;
    chk_hs("rstmid.r", 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
    chk("rstmid.ramaddr", ramaddr, '0);
    chk_state("rstmid");
    dREN = 1'b0; ramstate = FREE;
    #1 RST = 1'b0;
    next_cycle();

    for (int k = 0; k < 5; k++)
      run_txn("wrap", 1'b1, 1'b0, 32'h100 + 32'(k), 32'h0, k % 3, 1'b0, 32'hA5A5_0000 + 32'(k));
    chk("wrap.dcount", 32'(dcount), 32'd1);

    for (int n = 0; n < 40; n++) begin
      int nb;
      nb = ($urandom_range(0, 5) == 0) ? 6 : int'($urandom_range(0, 3));
      run_txn("rand", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              32'($urandom), 32'($urandom), nb, $urandom_range(0, 7) == 0, 32'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
